// File: rtl/vend_ctrl_multi.sv
// vend_ctrl_multi: multi-slot vending controller (coin entry, bulk purchase, timed dispense/change).
// Ports: clk, rst (sync, active-high), tick (10 ms strobe), set_req/pay_req (one-pulse mode requests),
//   key_valid/key_code (pre-decoded key, 0-9 digit, A enter, B space), seg_nums (four BCD nibbles,
//   A dash, B blank), led (status), disp_valid/disp_slot/disp_qty (dispense pulse), state_o (0..4).
// Option: define VEND_TIMEOUT_EN to return money after TIMEOUT_TICKS ticks without a key in PAY.
// SET entry always starts on the SLOT field. All outputs are registered from next-state values,
// so they line up with the state register in the same cycle.
module vend_ctrl_multi #(
   parameter int NUM_SLOTS     = 4,
   parameter int STOCK_INIT    = 9,
   parameter int PRICE_INIT    = 10,
   parameter int COIN1         = 1,
   parameter int COIN2         = 5,
   parameter int COIN3         = 10,
   parameter int COIN4         = 50,
   parameter int MAX_MONEY     = 99,
   parameter int FLASH_TICKS   = 50,
   parameter int DONE_TICKS    = 300,
   parameter int TIMEOUT_TICKS = 1000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick,
   input  logic        set_req,
   input  logic        pay_req,
   input  logic        key_valid,
   input  logic [3:0]  key_code,
   output logic [15:0] seg_nums,
   output logic [15:0] led,
   output logic        disp_valid,
   output logic [3:0]  disp_slot,
   output logic [3:0]  disp_qty,
   output logic [2:0]  state_o
);
   localparam logic [2:0] S_IDLE = 3'd0, S_SET = 3'd1, S_PAY = 3'd2, S_BUY = 3'd3, S_CHG = 3'd4;
   localparam logic [1:0] F_SLOT = 2'd0, F_STOCK = 2'd1, F_PRICE = 2'd2;
   logic [2:0]  state, state_n;
   logic [3:0]  sel, sel_n, qty, qty_n;
   logic [1:0]  field, field_n;
   logic [6:0]  money, money_n;
   logic [9:0]  tcnt, tcnt_n;
   // Arrays span the full 4-bit slot index; entries at or above NUM_SLOTS are never selected.
   logic [3:0]  stock [16];
   logic [3:0]  stock_n [16];
   logic [6:0]  price [16];
   logic [6:0]  price_n [16];
   logic        dv_n, dig, ent, spc, can_buy, tdone, blink;
   logic [3:0]  cur_stock, buy_qty;
   logic [6:0]  cur_price, fit, buy_cost, money_add, n_price, n_cost;
   logic [7:0]  coin, sum;
   logic [15:0] seg_d, led_d;

   function automatic logic [7:0] bcd2(input logic [6:0] v);
      return {4'(v / 7'd10), 4'(v % 7'd10)};
   endfunction

   assign dig       = key_valid && key_code < 4'd10;
   assign ent       = key_valid && key_code == 4'hA;
   assign spc       = key_valid && key_code == 4'hB;
   assign cur_stock = stock[sel];
   assign cur_price = price[sel];
   assign fit       = cur_price == 7'd0 ? 7'd0 : money / cur_price;
   assign buy_qty   = fit > {3'd0, cur_stock} ? cur_stock : fit[3:0];
   assign buy_cost  = {3'd0, buy_qty} * cur_price;
   assign can_buy   = cur_price != 7'd0 && cur_stock != 4'd0 && money >= cur_price;
   assign coin      = key_code == 4'd1 ? 8'(COIN1) : key_code == 4'd2 ? 8'(COIN2) :
                      key_code == 4'd3 ? 8'(COIN3) : 8'(COIN4);
   assign sum       = {1'b0, money} + coin;
   assign money_add = sum > 8'(MAX_MONEY) ? 7'(MAX_MONEY) : sum[6:0];
   assign tdone     = tick && tcnt == 10'(DONE_TICKS - 1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         sel        <= '0;
         field      <= F_SLOT;
         money      <= '0;
         qty        <= '0;
         tcnt       <= '0;
         for (int i = 0; i < 16; i++) begin
            stock[i] <= 4'(STOCK_INIT);
            price[i] <= 7'(PRICE_INIT);
         end
         seg_nums   <= 16'hAAAA;
         led        <= '0;
         disp_valid <= 1'b0;
         disp_slot  <= '0;
         disp_qty   <= '0;
         state_o    <= S_IDLE;
      end else begin
         state      <= state_n;
         sel        <= sel_n;
         field      <= field_n;
         money      <= money_n;
         qty        <= qty_n;
         tcnt       <= tcnt_n;
         stock      <= stock_n;
         price      <= price_n;
         seg_nums   <= seg_d;
         led        <= led_d;
         disp_valid <= dv_n;
         state_o    <= state_n;
         if (dv_n) begin
            disp_slot <= sel;
            disp_qty  <= qty_n;
         end
      end
   end

   always_comb begin
      state_n = state;
      sel_n   = sel;
      field_n = field;
      money_n = money;
      qty_n   = qty;
      tcnt_n  = tcnt;
      stock_n = stock;
      price_n = price;
      dv_n    = 1'b0;
      case (state)
         S_IDLE: begin
            money_n = '0;
            if (set_req) begin
               state_n = S_SET;
               field_n = F_SLOT;
            end else if (pay_req) begin
               state_n = S_PAY;
               tcnt_n  = '0;
            end
         end
         S_SET: begin
            if (ent) state_n = S_IDLE;
            else if (spc) field_n = field == F_PRICE ? F_SLOT : field + 2'd1;
            else if (dig) begin
               if (field == F_SLOT) sel_n = key_code < 4'(NUM_SLOTS) ? key_code : sel;
               else if (field == F_STOCK) stock_n[sel] = key_code;
               else price_n[sel] = (cur_price % 7'd10) * 7'd10 + {3'd0, key_code};
            end
         end
         S_PAY: begin
`ifdef VEND_TIMEOUT_EN
            // Ticks since the last key; reaching the limit refunds via CHANGE.
            if (key_valid) tcnt_n = '0;
            else if (tick) begin
               tcnt_n = tcnt == 10'(TIMEOUT_TICKS - 1) ? '0 : tcnt + 10'd1;
               if (tcnt == 10'(TIMEOUT_TICKS - 1)) begin
                  state_n = S_CHG;
                  qty_n   = '0;
               end
            end
`endif
            if (ent) begin
               tcnt_n = '0;
               if (can_buy) begin
                  qty_n        = buy_qty;
                  stock_n[sel] = cur_stock - buy_qty;
                  money_n      = money - buy_cost;
                  dv_n         = 1'b1;
                  state_n      = S_BUY;
               end else begin
                  qty_n   = '0;
                  state_n = S_CHG;
               end
            end else if (spc) sel_n = sel == 4'(NUM_SLOTS - 1) ? 4'd0 : sel + 4'd1;
            else if (dig) money_n = key_code == 4'd0 ? 7'd0 : key_code < 4'd5 ? money_add : money;
         end
         S_BUY: begin
            if (tick) tcnt_n = tdone ? '0 : tcnt + 10'd1;
            if (tdone) state_n = S_CHG;
         end
         S_CHG: begin
            if (tick) tcnt_n = tdone ? '0 : tcnt + 10'd1;
            if (tdone) begin
               state_n = S_IDLE;
               money_n = '0;
               qty_n   = '0;
            end
         end
         default: state_n = S_IDLE;
      endcase
   end

   always_comb begin
      n_price = price_n[sel_n];
      n_cost  = {3'd0, qty_n} * n_price;
      blink   = ((tcnt_n / 10'(FLASH_TICKS)) & 10'd1) != 10'd0;
      seg_d   = state_n == S_SET ? {sel_n, stock_n[sel_n], bcd2(n_price)} :
                state_n == S_PAY ? {sel_n, 4'hA, bcd2(money_n)} :
                state_n == S_BUY ? (blink ? 16'hBBBB : {qty_n, 4'hA, bcd2(n_cost)}) :
                state_n == S_CHG ? {qty_n, 4'hA, bcd2(money_n)} : 16'hAAAA;
      led_d   = state_n == S_SET ? (field_n == F_SLOT ? 16'hF000 : field_n == F_STOCK ? 16'h0F00 : 16'h00FF) :
                state_n == S_BUY ? (blink ? 16'h0000 : 16'hFFFF) :
                state_n == S_CHG ? 16'hFFFF : 16'h0000;
   end
endmodule

// File: tb/tb_vend_ctrl_multi.sv
// tb_vend_ctrl_multi: directed and randomized bench for vend_ctrl_multi against a behavioural model.
module tb_vend_ctrl_multi;
   localparam int NS = 4, DT = 300, FT = 50, TO = 1000;
   logic        clk = 0, rst = 1, tick = 0, set_req = 0, pay_req = 0, key_valid = 0;
   logic [3:0]  key_code = 0;
   logic [15:0] seg_nums, led;
   logic        disp_valid;
   logic [3:0]  disp_slot, disp_qty;
   logic [2:0]  state_o;
   int cmp_n = 0, err_n = 0;
   // Model: mode 0 idle, 1 set, 2 pay, 3 vend; el = ticks since vend start (BUY below DT, CHANGE below 2*DT).
   int mode = 0, m_sel = 0, m_field = 0, m_money = 0, m_qty = 0, el = 0, pidle = 0, m_dslot = 0, m_dqty = 0;
   int m_stock [NS];
   int m_price [NS];
   int coin [5] = '{0, 1, 5, 10, 50};
   bit m_dv = 0, armed = 0;

   vend_ctrl_multi dut (.clk(clk), .rst(rst), .tick(tick), .set_req(set_req), .pay_req(pay_req),
      .key_valid(key_valid), .key_code(key_code), .seg_nums(seg_nums), .led(led),
      .disp_valid(disp_valid), .disp_slot(disp_slot), .disp_qty(disp_qty), .state_o(state_o));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      cmp_n++;
      if (act !== exp) begin
         err_n++;
         $display("FAIL %s: got %0h, want %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] h4(input int a, input int b, input int c, input int d);
      return 16'((a << 12) | (b << 8) | (c << 4) | d);
   endfunction

   task automatic model_step();
      int kc, p;
      kc = int'(key_code);
      m_dv = 0;
      if (rst) begin
         armed = 1; mode = 0; m_sel = 0; m_field = 0; m_money = 0; m_qty = 0; el = 0; pidle = 0;
         for (int i = 0; i < NS; i++) begin
            m_stock[i] = 9;
            m_price[i] = 10;
         end
      end else if (mode == 0) begin
         m_money = 0;
         if (set_req) begin
            mode = 1;
            m_field = 0;
         end else if (pay_req) begin
            mode = 2;
            pidle = 0;
         end
      end else if (mode == 1) begin
         if (key_valid) begin
            if (kc == 10) mode = 0;
            else if (kc == 11) m_field = (m_field + 1) % 3;
            else if (kc < 10) begin
               if (m_field == 0) begin
                  if (kc < NS) m_sel = kc;
               end else if (m_field == 1) m_stock[m_sel] = kc;
               else m_price[m_sel] = (m_price[m_sel] % 10) * 10 + kc;
            end
         end
      end else if (mode == 2) begin
`ifdef VEND_TIMEOUT_EN
         if (key_valid) pidle = 0;
         else if (tick) begin
            pidle++;
            if (pidle == TO) begin
               mode = 3;
               el = DT;
               m_qty = 0;
            end
         end
`endif
         if (key_valid) begin
            p = m_price[m_sel];
            if (kc == 10) begin
               mode = 3;
               if (p > 0 && m_stock[m_sel] > 0 && m_money >= p) begin
                  m_qty = m_money / p;
                  if (m_qty > m_stock[m_sel]) m_qty = m_stock[m_sel];
                  m_stock[m_sel] -= m_qty;
                  m_money -= m_qty * p;
                  m_dv = 1; m_dslot = m_sel; m_dqty = m_qty; el = 0;
               end else begin
                  m_qty = 0;
                  el = DT;
               end
            end else if (kc == 11) m_sel = (m_sel + 1) % NS;
            else if (kc == 0) m_money = 0;
            else if (kc <= 4) m_money = m_money + coin[kc] > 99 ? 99 : m_money + coin[kc];
         end
      end else if (tick) begin
         el++;
         if (el == 2 * DT) begin
            mode = 0; m_money = 0; m_qty = 0;
         end
      end
   endtask

   task automatic compare();
      int code;
      logic [15:0] es, ls;
      code = mode < 3 ? mode : (el < DT ? 3 : 4);
      es = 16'hAAAA;
      ls = 16'h0000;
      if (code == 1) begin
         es = h4(m_sel, m_stock[m_sel], m_price[m_sel] / 10, m_price[m_sel] % 10);
         ls = m_field == 0 ? 16'hF000 : m_field == 1 ? 16'h0F00 : 16'h00FF;
      end else if (code == 2) es = h4(m_sel, 10, m_money / 10, m_money % 10);
      else if (code == 3) begin
         if ((el / FT) % 2 == 1) es = 16'hBBBB;
         else begin
            es = h4(m_qty, 10, (m_qty * m_price[m_sel]) / 10, (m_qty * m_price[m_sel]) % 10);
            ls = 16'hFFFF;
         end
      end else if (code == 4) begin
         es = h4(m_qty, 10, m_money / 10, m_money % 10);
         ls = 16'hFFFF;
      end
      chk("state_o", 32'(state_o), 32'(code));
      chk("seg_nums", 32'(seg_nums), 32'(es));
      chk("led", 32'(led), 32'(ls));
      chk("disp_valid", 32'(disp_valid), 32'(m_dv));
      if (m_dv) begin
         chk("disp_slot", 32'(disp_slot), 32'(m_dslot));
         chk("disp_qty", 32'(disp_qty), 32'(m_dqty));
      end
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   initial forever begin
      @(negedge clk);
      if (armed) compare();
   end

   task automatic drive(input bit t, input bit s, input bit p, input bit kv, input logic [3:0] kc);
      @(negedge clk);
      tick = t; set_req = s; pay_req = p; key_valid = kv; key_code = kc;
      @(posedge clk);
      #1;
      tick = 0; set_req = 0; pay_req = 0; key_valid = 0; key_code = 0;
   endtask

   task automatic key(input logic [3:0] k);
      drive(0, 0, 0, 1, k);
   endtask

   task automatic ticks(input int n);
      repeat (n) drive(1, 0, 0, 0, 4'd0);
   endtask

   task automatic pulse_rst();
      @(negedge clk);
      rst = 1;
      @(posedge clk);
      #1 rst = 0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1 rst = 0;
      chk("rst seg", 32'(seg_nums), 32'h0000AAAA);
      chk("rst state", 32'(state_o), 0);
      chk("rst led", 32'(led), 0);
      // Purchase of two at price 10 with 25 inserted.
      drive(0, 0, 1, 0, 4'd0);
      key(4'd3); key(4'd3); key(4'd2);
      chk("pay seg 25", 32'(seg_nums), 32'h00000A25);
      key(4'hA);
      chk("buy dv", 32'(disp_valid), 1);
      chk("buy qty", 32'(disp_qty), 2);
      chk("buy seg", 32'(seg_nums), 32'h00002A20);
      ticks(DT);
      chk("change state", 32'(state_o), 4);
      chk("change seg", 32'(seg_nums), 32'h00002A05);
      ticks(DT - 1);
      chk("change hold", 32'(state_o), 4);
      ticks(1);
      chk("back idle", 32'(state_o), 0);
      // Saturation, clear, refused purchase.
      drive(0, 0, 1, 0, 4'd0);
      key(4'd4); key(4'd4);
      chk("sat 99", 32'(seg_nums), 32'h00000A99);
      key(4'd0); key(4'hA);
      chk("refuse seg", 32'(seg_nums), 32'h00000A00);
      chk("refuse state", 32'(state_o), 4);
      ticks(DT);
      // Edit stock 3 and price 15, then stock-limited purchase.
      drive(0, 1, 0, 0, 4'd0);
      chk("set seg", 32'(seg_nums), 32'h00000710);
      chk("set led", 32'(led), 32'h0000F000);
      key(4'hB); key(4'd3); key(4'hB); key(4'd1); key(4'd5);
      chk("set price", 32'(seg_nums), 32'h00000315);
      chk("price led", 32'(led), 32'h000000FF);
      key(4'hA);
      drive(0, 0, 1, 0, 4'd0);
      key(4'd4); key(4'hA);
      chk("limited qty", 32'(disp_qty), 3);
      chk("limited seg", 32'(seg_nums), 32'h00003A45);
      ticks(DT);
      chk("limited change", 32'(seg_nums), 32'h00003A05);
      ticks(DT);
      // Slot key beyond NUM_SLOTS ignored; zero price refuses.
      drive(0, 1, 0, 0, 4'd0);
      key(4'd7);
      chk("slot 7 ignored", 32'(seg_nums), 32'h00000015);
      key(4'hB); key(4'hB); key(4'd0); key(4'd0); key(4'hA);
      drive(0, 0, 1, 0, 4'd0);
      key(4'd3); key(4'hA);
      chk("price0 seg", 32'(seg_nums), 32'h00000A10);
      chk("price0 state", 32'(state_o), 4);
      ticks(DT);
      // Blink window and reset during BUY.
      drive(0, 1, 0, 0, 4'd0);
      key(4'd1); key(4'hA);
      drive(0, 0, 1, 0, 4'd0);
      key(4'd3); key(4'hA);
      chk("slot1 buy", 32'(seg_nums), 32'h00001A10);
      ticks(FT);
      chk("blink seg", 32'(seg_nums), 32'h0000BBBB);
      chk("blink led", 32'(led), 0);
      ticks(70);
      chk("tick120 seg", 32'(seg_nums), 32'h00001A10);
      pulse_rst();
      chk("midbuy rst", 32'(seg_nums), 32'h0000AAAA);
      drive(0, 1, 0, 0, 4'd0);
      chk("stock restored", 32'(seg_nums), 32'h00000910);
      key(4'hA);
`ifdef VEND_TIMEOUT_EN
      drive(0, 0, 1, 0, 4'd0);
      key(4'd3);
      ticks(TO - 1);
      chk("timeout wait", 32'(state_o), 2);
      ticks(1);
      chk("timeout seg", 32'(seg_nums), 32'h00000A10);
      ticks(DT);
`endif
      repeat (20000) begin
         if ($urandom_range(0, 2999) == 0) pulse_rst();
         else drive($urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 3) == 0, 4'($urandom_range(0, 15)));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
      $finish;
   end
endmodule
